// File: rtl/rom_fetch_responder_pkg.sv
// Shared definitions for the program-memory responder: bus cycle numbering
// and the cycle-advance rule used by the top-level sequencer.
package rom_fetch_responder_pkg;

  typedef logic [2:0] cycle_t;

  // Bus cycle numbering shared with the CPU sequencer and pc logic.
  localparam cycle_t CYC_A1 = 3'd0;  // PC low nibble
  localparam cycle_t CYC_A2 = 3'd1;  // PC high nibble
  localparam cycle_t CYC_A3 = 3'd2;  // chip-select nibble
  localparam cycle_t CYC_M1 = 3'd3;  // OPR returned
  localparam cycle_t CYC_M2 = 3'd4;  // OPA returned

  typedef struct packed {
    logic       oe;
    logic [3:0] nibble;
  } bus_drive_t;

  localparam bus_drive_t BUS_IDLE = '{oe: 1'b0, nibble: 4'h0};

  // sync restarts the frame; a plain increment wraps 7 -> 0 on its own.
  function automatic cycle_t advance_cycle(input cycle_t cur, input logic sync);
    advance_cycle = sync ? CYC_A1 : cur + 3'd1;
  endfunction

endpackage

// File: rtl/rom_fetch_responder_rom_array.sv
// Writable instruction store: one synchronous write port for the programming
// interface, one combinational read port sampled by the fetch logic.
module rom_fetch_responder_rom_array #(
  parameter int ADDR_BITS = 4
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [7:0]           wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [7:0]           rdata
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  // Contents deliberately carry no reset; they are loaded through the
  // programming port.
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A same-edge write lands after the fetch has sampled, so the reader
  // always sees the pre-write byte.
  assign rdata = mem[raddr];

endmodule

// File: rtl/rom_fetch_responder.sv
// Program-memory responder on the 4-bit multiplexed instruction bus: latches
// the PC and chip select in cycles 0-2, returns OPR/OPA in cycles 3-4.
module rom_fetch_responder #(
  parameter int         ADDR_BITS = 4,
  parameter logic [3:0] CHIP_ID   = 4'h0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sync,
  input  logic       halt,
  input  logic [3:0] bus_in,
  output logic [3:0] bus_out,
  output logic       bus_oe,
  input  logic       prog_en,
  input  logic       prog_we,
  input  logic [7:0] prog_addr,
  input  logic [7:0] prog_data
);

  import rom_fetch_responder_pkg::*;

  cycle_t     cycle_reg,    cycle_next;
  logic [7:0] addr_reg,     addr_next;
  logic       selected_reg, selected_next;
  logic [7:0] data_reg,     data_next;
  bus_drive_t drive_reg,    drive_next;
  logic [7:0] rd_data;

  rom_fetch_responder_rom_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_rom_array (
    .clock (clock),
    .we    (prog_en & prog_we),
    .waddr (prog_addr[ADDR_BITS-1:0]),
    .wdata (prog_data),
    .raddr (addr_reg[ADDR_BITS-1:0]),
    .rdata (rd_data)
  );

  // Address bits above the implemented depth simply alias.
  generate
    if (ADDR_BITS < 8) begin : g_alias
      logic unused_addr_bits;
      assign unused_addr_bits = ^{prog_addr[7:ADDR_BITS], addr_reg[7:ADDR_BITS]};
    end
  endgenerate

  always_comb begin
    cycle_next    = cycle_reg;
    addr_next     = addr_reg;
    selected_next = selected_reg;
    data_next     = data_reg;

    if (!halt) begin
      cycle_next = advance_cycle(cycle_reg, sync);
      case (cycle_reg)
        CYC_A1: addr_next[3:0] = bus_in;
        CYC_A2: addr_next[7:4] = bus_in;
        CYC_A3: begin
          selected_next = (bus_in == CHIP_ID) && !prog_en;
          data_next     = rd_data;
        end
        default: ;
      endcase
    end

    // Entering programming mode abandons any pending fetch.
    if (prog_en) begin
      selected_next = 1'b0;
    end
  end

  // The drive is computed from the post-edge state so the first nibble is
  // valid for the whole of cycle 3.
  always_comb begin
    drive_next = drive_reg;
    if (prog_en) begin
      drive_next = BUS_IDLE;
    end else if (!halt) begin
      drive_next = BUS_IDLE;
      if (selected_next) begin
        case (cycle_next)
          CYC_M1:  drive_next = '{oe: 1'b1, nibble: data_next[7:4]};
          CYC_M2:  drive_next = '{oe: 1'b1, nibble: data_next[3:0]};
          default: drive_next = BUS_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_reg    <= CYC_A1;
      addr_reg     <= 8'h00;
      selected_reg <= 1'b0;
      data_reg     <= 8'h00;
      drive_reg    <= BUS_IDLE;
    end else begin
      cycle_reg    <= cycle_next;
      addr_reg     <= addr_next;
      selected_reg <= selected_next;
      data_reg     <= data_next;
      drive_reg    <= drive_next;
    end
  end

  assign bus_out = drive_reg.nibble;
  assign bus_oe  = drive_reg.oe;

endmodule

// File: tb/tb_rom_fetch_responder.sv
// Directed bench for rom_fetch_responder: fetch, deselect, aliasing, halt,
// sync abort, programming interaction and reset mid-fetch.
module tb_rom_fetch_responder;

  localparam logic [3:0] CHIP = 4'h9;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sync = 1'b0;
  logic       halt = 1'b0;
  logic [3:0] bus_in = 4'h0;
  logic [3:0] bus_out;
  logic       bus_oe;
  logic       prog_en = 1'b0;
  logic       prog_we = 1'b0;
  logic [7:0] prog_addr = 8'h00;
  logic [7:0] prog_data = 8'h00;

  int checks = 0;
  int failures = 0;

  rom_fetch_responder #(
    .ADDR_BITS (4),
    .CHIP_ID   (CHIP)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .sync      (sync),
    .halt      (halt),
    .bus_in    (bus_in),
    .bus_out   (bus_out),
    .bus_oe    (bus_oe),
    .prog_en   (prog_en),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic step(input logic [3:0] b, input logic s);
    bus_in = b;
    sync   = s;
    @(posedge clock);
    #1;
    sync   = 1'b0;
  endtask

  function automatic logic [7:0] cyc();
    return {5'd0, dut.cycle_reg};
  endfunction

  function automatic logic [7:0] oe8();
    return {7'd0, bus_oe};
  endfunction

  function automatic logic [7:0] out8();
    return {4'd0, bus_out};
  endfunction

  // Full 8-cycle frame starting from cycle 0.
  task automatic fetch(input string tag, input logic [7:0] a, input logic [3:0] chip,
                       input logic exp_oe, input logic [7:0] exp_byte, input logic use_sync);
    check({tag, " start_cycle"}, cyc(), 8'd0);
    step(a[3:0], 1'b0);
    step(a[7:4], 1'b0);
    step(chip, 1'b0);
    check({tag, " c3_oe"}, oe8(), {7'd0, exp_oe});
    check({tag, " c3_out"}, out8(), exp_oe ? {4'd0, exp_byte[7:4]} : 8'h00);
    step(4'h0, 1'b0);
    check({tag, " c4_oe"}, oe8(), {7'd0, exp_oe});
    check({tag, " c4_out"}, out8(), exp_oe ? {4'd0, exp_byte[3:0]} : 8'h00);
    for (int i = 5; i < 8; i++) begin
      step(4'h0, 1'b0);
      check($sformatf("%s c%0d_oe", tag, i), oe8(), 8'h00);
    end
    step(4'h0, use_sync);
    check({tag, " end_cycle"}, cyc(), 8'd0);
  endtask

  // Advance from cycle 4 back to cycle 0.
  task automatic drain_from_c4();
    for (int i = 0; i < 4; i++) step(4'h0, 1'b0);
  endtask

  initial begin
    // Program while held in reset; writes do not depend on reset.
    prog_en = 1'b1;
    prog_we = 1'b1;
    prog_addr = 8'h05; prog_data = 8'hA3;
    @(posedge clock); #1;
    prog_addr = 8'h00; prog_data = 8'hC4;
    @(posedge clock); #1;
    prog_en = 1'b0;
    prog_we = 1'b0;
    check("reset oe", oe8(), 8'h00);
    check("reset out", out8(), 8'h00);
    check("reset cycle", cyc(), 8'h00);
    check("reset addr", dut.addr_reg, 8'h00);
    reset = 1'b0;

    fetch("t1_fetch5", 8'h05, CHIP, 1'b1, 8'hA3, 1'b1);
    fetch("t2_deselect", 8'h05, 4'h2, 1'b0, 8'hA3, 1'b0);
    fetch("t3_alias35", 8'h35, CHIP, 1'b1, 8'hA3, 1'b0);

    // Halt in cycle 1 with a distractor nibble on the bus.
    step(4'h5, 1'b0);
    halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(4'hF, 1'b1);
      check($sformatf("t4 halt%0d_cycle", i), cyc(), 8'd1);
    end
    halt = 1'b0;
    step(4'h0, 1'b0);
    check("t4 addr_after_halt", dut.addr_reg, 8'h05);
    check("t4 c2_oe", oe8(), 8'h00);
    step(CHIP, 1'b0);
    check("t4 c3_out", out8(), 8'h0A);
    check("t4 c3_oe", oe8(), 8'h01);
    step(4'h0, 1'b0);
    check("t4 c4_out", out8(), 8'h03);
    drain_from_c4();

    // sync during cycle 3 abandons the fetch.
    step(4'h5, 1'b0);
    step(4'h0, 1'b0);
    step(CHIP, 1'b0);
    check("t5 c3_oe", oe8(), 8'h01);
    step(4'h0, 1'b1);
    check("t5 sync_oe", oe8(), 8'h00);
    check("t5 sync_cycle", cyc(), 8'h00);
    fetch("t5_fetch0", 8'h00, CHIP, 1'b1, 8'hC4, 1'b1);

    // prog_en raised mid-fetch drops the bus on the next edge.
    step(4'h5, 1'b0);
    step(4'h0, 1'b0);
    step(CHIP, 1'b0);
    check("pe c3_oe", oe8(), 8'h01);
    prog_en = 1'b1;
    step(4'h0, 1'b0);
    check("pe c4_oe", oe8(), 8'h00);
    check("pe c4_out", out8(), 8'h00);
    prog_en = 1'b0;
    step(4'h0, 1'b0);
    check("pe c5_oe", oe8(), 8'h00);
    for (int i = 0; i < 3; i++) step(4'h0, 1'b0);

    // Write on the cycle-2 edge: the fetch latch takes the old byte; the
    // programming mode itself suppresses the response.
    step(4'h5, 1'b0);
    step(4'h0, 1'b0);
    prog_en = 1'b1; prog_we = 1'b1; prog_addr = 8'h05; prog_data = 8'h7E;
    step(CHIP, 1'b0);
    prog_en = 1'b0; prog_we = 1'b0;
    check("t6 old_data", dut.data_reg, 8'hA3);
    check("t6 c3_oe", oe8(), 8'h00);
    step(4'h0, 1'b0);
    drain_from_c4();
    fetch("t6_new5", 8'h05, CHIP, 1'b1, 8'h7E, 1'b1);

    // Reset during cycle 3.
    step(4'h5, 1'b0);
    step(4'h0, 1'b0);
    step(CHIP, 1'b0);
    check("t6r c3_out", out8(), 8'h07);
    reset = 1'b1;
    step(4'h0, 1'b0);
    check("t6r oe", oe8(), 8'h00);
    check("t6r out", out8(), 8'h00);
    check("t6r cycle", cyc(), 8'h00);
    reset = 1'b0;
    fetch("t6r_refetch", 8'h05, CHIP, 1'b1, 8'h7E, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
